csr_row_mac: RTL
================

# csr_row_mac

Consumer end of the weight-fetch path: pops CSR-encoded sparse-matrix streams (row lengths, nonzero values, column indices) from three standard (non-FWFT) 8-bit FIFOs. Per row it multiplies each value by the dense input-vector element at its column and accumulates the products. It emits one signed row sum per row over a valid/ready port, where it feeds the activation/output stage.

## Interface
- `ACC_W`, 24: accumulator and result width, in bits.
- `ROW_W`, 16: row-index width.
- `NUM_ROWS`, 100: rows per matrix; block halts after this many results.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `len_empty`  in  1  length FIFO empty.
- `len_read`  out  1  length FIFO rd_en.
- `len_data`  in  8  length FIFO dout, unsigned count of nonzeros in row.
- `val_empty`  in  1  value FIFO empty.
- `val_read`  out  1  value FIFO rd_en.
- `val_data`  in  8  value FIFO dout, signed two's complement.
- `col_empty`  in  1  column FIFO empty.
- `col_read`  out  1  column FIFO rd_en.
- `col_data`  in  8  column FIFO dout, unsigned index.
- `x_addr`  out  8  registered input-vector address.
- `x_data`  in  8  input-vector element, signed; async read, valid in the same cycle as `x_addr`.
- `y_valid`  out  1  result valid.
- `y_ready`  in  1  downstream accepts result.
- `y_data`  out  ACC_W  signed row sum.
- `y_row`  out  ROW_W  index of current/presented row.
- `rows_done`  out  1  all NUM_ROWS results accepted; sticky until reset.

## Operation
- FIFO protocol: the FIFOs use standard mode. `dout` is valid the cycle after `rd_en`. A read strobe is asserted only when the matching empty is low, is a one-cycle pulse, and is combinational from state and empty. All strobes are forced 0 while `rst` is high.
- FSM states: LEN_REQ (reset state), LEN_WAIT, ELEM_REQ, ELEM_WAIT, MAC, OUT, DONE.
  - LEN_REQ: `len_read` = ~len_empty. Advance to LEN_WAIT when asserted.
  - LEN_WAIT: `remaining` <= len_data; `acc` <= 0. Go to OUT if len_data==0, else ELEM_REQ.
  - ELEM_REQ: `val_read` = `col_read` = ~val_empty & ~col_empty. Both pop together or neither pops. Advance to ELEM_WAIT when popped.
  - ELEM_WAIT: `val_q` <= val_data; `x_addr` <= col_data; go to MAC.
  - MAC: `acc` <= acc + sext(val_q*x_data), using a signed 8x8 to 16-bit product; `remaining` decrements. Go to OUT when remaining==1, else ELEM_REQ.
  - OUT: `y_valid`=1, with `y_data`=acc and `y_row` stable. On y_valid&y_ready, `y_row` increments. Go to DONE if the new `y_row`==NUM_ROWS (`rows_done`<=1), else LEN_REQ.
  - DONE: no strobes, `y_valid`=0. Held until reset.
- Arithmetic: accumulation wraps modulo 2^ACC_W with no saturation. A row of 255 × (-128·-128) = 4177920 fits the default width.
- `y_data` is the `acc` register. Its value is meaningful only while `y_valid` is high.
- Stalls: an empty FIFO holds the FSM in its REQ state indefinitely. No state advances and no data is lost.
- Reset mid-operation clears all state immediately. Partially accumulated rows are discarded (the FIFOs share `rst`).
- Reset values: `len_read`/`val_read`/`col_read` 0, `x_addr` 0, `y_valid` 0, `y_data` 0, `y_row` 0, `rows_done` 0.

## Timing
- Length pop at cycle t gives LEN_WAIT at t+1.
- With no stalls, `y_valid` rises at t+2+3N for a row of N nonzeros. For N=0 that is t+2, with `y_data`=0.
- Each element takes 3 cycles: pop, capture, MAC.
- After an accepted handshake in cycle u, the next `len_read` can assert in u+1.
- Backpressure: `y_valid`, `y_data` and `y_row` hold unchanged while y_ready=0. No FIFO is read in OUT.
- y_ready high while `y_valid` is low has no effect.

## Test plan
- Basic row: len=2, vals {3,-2}, cols {5,7}, x[5]=4, x[7]=10, y_ready=1 -> `y_valid` at t+8, `y_data`=-8, `y_row`=0, then `len_read` at the next cycle.
- Empty row: len=0 -> `y_valid` at t+2 with `y_data`=0. `val_read`/`col_read` are never asserted.
- Stalls: hold col_empty=1 for 5 cycles with val_empty=0 -> no strobe fires. After release, both strobes pulse together once and the result is unchanged versus the unstalled run. Randomized empties on all three FIFOs match a reference model.
- Backpressure: y_ready=0 for 10 cycles in OUT -> outputs stable, no reads. Handshake on release, then `y_row` increments.
- Max magnitude: len=255, all vals=-128, all x=-128 -> `y_data`=4177920. Check wrap with ACC_W=16 against a modulo-2^16 model.
- Completion and reset: NUM_ROWS=2 -> `rows_done` is 1 after the 2nd handshake and the block is idle thereafter. Asserting `rst` mid-row returns all outputs to reset values asynchronously. Restart then yields correct row 0.

Source files
------------

// File: rtl/csr_row_mac.sv
// CSR sparse row dot-product: pops length/value/column streams, emits one signed sum per row.
// Latency 2+3N cycles from length pop for N nonzeros; y_* hold and no FIFO is read while y_ready is low.
module csr_row_mac #(
  parameter int ACC_W    = 24,
  parameter int ROW_W    = 16,
  parameter int NUM_ROWS = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             len_empty,
  output logic             len_read,
  input  logic [7:0]       len_data,
  input  logic             val_empty,
  output logic             val_read,
  input  logic [7:0]       val_data,
  input  logic             col_empty,
  output logic             col_read,
  input  logic [7:0]       col_data,
  output logic [7:0]       x_addr,
  input  logic [7:0]       x_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [ACC_W-1:0] y_data,
  output logic [ROW_W-1:0] y_row,
  output logic             rows_done
);

  typedef enum logic [2:0] {
    LEN_REQ,
    LEN_WAIT,
    ELEM_REQ,
    ELEM_WAIT,
    MAC,
    OUT,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [7:0]         remaining;
  logic signed [7:0]  val_q;
  logic [ACC_W-1:0]   acc;
  logic signed [15:0] prod;
  logic [ACC_W-1:0]   prod_ext;
  logic               elem_avail;
  logic [ROW_W-1:0]   row_nxt;
  logic               last_row;

  assign prod       = val_q * $signed(x_data);
  assign prod_ext   = ACC_W'(prod);
  assign elem_avail = ~val_empty & ~col_empty;
  assign row_nxt    = y_row + ROW_W'(1);
  assign last_row   = (row_nxt == ROW_W'(NUM_ROWS));
  assign y_data     = acc;

  always_comb begin
    state_nxt = state;
    len_read  = 1'b0;
    val_read  = 1'b0;
    col_read  = 1'b0;
    y_valid   = 1'b0;
    case (state)
      LEN_REQ: begin
        len_read = ~len_empty & ~rst;
        if (~len_empty) state_nxt = LEN_WAIT;
      end
      LEN_WAIT:  state_nxt = (len_data == 8'd0) ? OUT : ELEM_REQ;
      ELEM_REQ: begin
        // value and column must leave their FIFOs in lockstep
        val_read = elem_avail & ~rst;
        col_read = elem_avail & ~rst;
        if (elem_avail) state_nxt = ELEM_WAIT;
      end
      ELEM_WAIT: state_nxt = MAC;
      MAC:       state_nxt = (remaining == 8'd1) ? OUT : ELEM_REQ;
      OUT: begin
        y_valid = 1'b1;
        if (y_ready) state_nxt = last_row ? DONE : LEN_REQ;
      end
      DONE:      state_nxt = DONE;
      default:   state_nxt = LEN_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LEN_REQ;
      remaining <= '0;
      val_q     <= '0;
      x_addr    <= '0;
      acc       <= '0;
      y_row     <= '0;
      rows_done <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        LEN_WAIT: begin
          remaining <= len_data;
          acc       <= '0;
        end
        ELEM_WAIT: begin
          val_q  <= $signed(val_data);
          x_addr <= col_data;
        end
        MAC: begin
          acc       <= acc + prod_ext;
          remaining <= remaining - 8'd1;
        end
        OUT: begin
          if (y_ready) begin
            y_row <= row_nxt;
            if (last_row) rows_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
